// File: rtl/dram_model_mc.sv
// Multi-channel DRAM timing model: independent per-channel request FSMs sharing one byte array.
// Each request is answered after a fixed read or write latency with a held, per-lane flagged response.
module dram_model_mc #(
    parameter int NUM_CH    = 2,
    parameter int LANES     = 8,
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 1024,
    parameter int RD_LAT    = 20,
    parameter int WR_LAT    = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_wr,
    input  logic [NUM_CH*LANES-1:0]      req_lane_en,
    input  logic [NUM_CH*LANES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LANES*8-1:0]    req_wdata,
    output logic [NUM_CH-1:0]            resp_valid,
    input  logic [NUM_CH-1:0]            resp_ready,
    output logic [NUM_CH-1:0]            resp_wr,
    output logic [NUM_CH*LANES-1:0]      resp_lane_valid,
    output logic [NUM_CH*LANES-1:0]      resp_err,
    output logic [NUM_CH*LANES*8-1:0]    resp_rdata,
    output logic [2*NUM_CH-1:0]          dbg_state
);

    // Handshake: a request transfers on an edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready.
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int IDX_W   = $clog2(MEM_BYTES);
    localparam int NL      = NUM_CH * LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q [NUM_CH];
    state_t             state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]  wr_q, wr_d;
    logic [NL-1:0]      en_q, en_d;
    logic [NL*ADDR_W-1:0] addr_q, addr_d;
    logic [NL*8-1:0]    wdata_q, wdata_d;
    logic [NUM_CH-1:0]  resp_wr_q, resp_wr_d;
    logic [NL-1:0]      lane_valid_q, lane_valid_d;
    logic [NL-1:0]      err_q, err_d;
    logic [NL*8-1:0]    rdata_q, rdata_d;

    logic [7:0]         mem_q [MEM_BYTES];
    logic [NUM_CH-1:0]  access;
    logic [NL-1:0]      lane_ok;
    logic [IDX_W-1:0]   lane_idx [NL];

    function automatic logic [CNT_W-1:0] last_cnt(input logic wr);
        return wr ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
    endfunction

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            lane_ok[i]  = en_q[i] && (addr_q[i*ADDR_W +: ADDR_W] < ADDR_W'(MEM_BYTES));
            lane_idx[i] = addr_q[i*ADDR_W +: IDX_W];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            access[c] = (state_q[c] == BUSY) && (cnt_q[c] == last_cnt(wr_q[c]));
        end
    end

    always_comb begin
        wr_d         = wr_q;
        en_d         = en_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_wr_d    = resp_wr_q;
        lane_valid_d = lane_valid_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            case (state_q[c])
                IDLE: begin
                    if (req_valid[c]) begin
                        wr_d[c]                                = req_wr[c];
                        en_d[c*LANES +: LANES]                 = req_lane_en[c*LANES +: LANES];
                        addr_d[c*LANES*ADDR_W +: LANES*ADDR_W] = req_addr[c*LANES*ADDR_W +: LANES*ADDR_W];
                        wdata_d[c*LANES*8 +: LANES*8]          = req_wdata[c*LANES*8 +: LANES*8];
                        cnt_d[c]                               = '0;
                        state_d[c]                             = BUSY;
                    end
                end
                BUSY: begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    if (access[c]) begin
                        state_d[c]   = RESP;
                        resp_wr_d[c] = wr_q[c];
                        for (int l = 0; l < LANES; l++) begin
                            lane_valid_d[c*LANES+l] = lane_ok[c*LANES+l];
                            err_d[c*LANES+l]        = en_q[c*LANES+l] && !lane_ok[c*LANES+l];
                            rdata_d[(c*LANES+l)*8 +: 8] =
                                (!wr_q[c] && lane_ok[c*LANES+l]) ? mem_q[lane_idx[c*LANES+l]] : 8'h00;
                        end
                    end
                end
                RESP: begin
                    // Clearing on exit keeps every resp_* output at zero whenever resp_valid is low.
                    if (resp_ready[c]) begin
                        state_d[c]                    = IDLE;
                        resp_wr_d[c]                  = 1'b0;
                        lane_valid_d[c*LANES +: LANES] = '0;
                        err_d[c*LANES +: LANES]       = '0;
                        rdata_d[c*LANES*8 +: LANES*8] = '0;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
            end
            wr_q         <= '0;
            en_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_wr_q    <= '0;
            lane_valid_q <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            wr_q         <= wr_d;
            en_q         <= en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_wr_q    <= resp_wr_d;
            lane_valid_q <= lane_valid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Later loop iterations win: highest channel, then highest lane, on a shared address.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int l = 0; l < LANES; l++) begin
                if (access[c] && wr_q[c] && lane_ok[c*LANES+l]) begin
                    mem_q[lane_idx[c*LANES+l]] <= wdata_q[(c*LANES+l)*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            req_ready[c]         = (state_q[c] == IDLE);
            resp_valid[c]        = (state_q[c] == RESP);
            dbg_state[2*c +: 2]  = state_q[c];
        end
    end

    assign resp_wr         = resp_wr_q;
    assign resp_lane_valid = lane_valid_q;
    assign resp_err        = err_q;
    assign resp_rdata      = rdata_q;

endmodule

// File: tb/tb_dram_model_mc.sv
// Bench for dram_model_mc: directed scenarios plus random traffic against a
// transaction-level model (due-cycle per request, byte array, ordered commit list).
module tb_dram_model_mc;
  localparam int NUM_CH = 2;
  localparam int LANES = 8;
  localparam int ADDR_W = 64;
  localparam int MEM_BYTES = 1024;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 5;
  localparam int NL = NUM_CH * LANES;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NUM_CH-1:0] req_valid = '0;
  logic [NUM_CH-1:0] req_ready;
  logic [NUM_CH-1:0] req_wr = '0;
  logic [NL-1:0] req_lane_en = '0;
  logic [NL*ADDR_W-1:0] req_addr = '0;
  logic [NL*8-1:0] req_wdata = '0;
  logic [NUM_CH-1:0] resp_valid;
  logic [NUM_CH-1:0] resp_ready = '1;
  logic [NUM_CH-1:0] resp_wr;
  logic [NL-1:0] resp_lane_valid;
  logic [NL-1:0] resp_err;
  logic [NL*8-1:0] resp_rdata;
  logic [2*NUM_CH-1:0] dbg_state;

  dram_model_mc #(
    .NUM_CH(NUM_CH), .LANES(LANES), .ADDR_W(ADDR_W),
    .MEM_BYTES(MEM_BYTES), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_lane_en(req_lane_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
    .resp_lane_valid(resp_lane_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] mem_m [MEM_BYTES];
  bit m_busy [NUM_CH];
  bit m_resp [NUM_CH];
  int m_due [NUM_CH];
  bit m_wr [NUM_CH];
  logic [LANES-1:0] m_en [NUM_CH];
  logic [ADDR_W-1:0] m_addr [NUM_CH][LANES];
  logic [7:0] m_wd [NUM_CH][LANES];
  bit e_wr [NUM_CH];
  logic [LANES-1:0] e_lv [NUM_CH];
  logic [LANES-1:0] e_err [NUM_CH];
  logic [LANES*8-1:0] e_rd [NUM_CH];
  int cyc = 0;

  task automatic chk(input string tag, input int c, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d t=%0t got=%h exp=%h", tag, c, $time, got, exp);
    end
  endtask

  task automatic clear_exp(input int c);
    e_wr[c] = 1'b0;
    e_lv[c] = '0;
    e_err[c] = '0;
    e_rd[c] = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_busy[c] = 1'b0;
      m_resp[c] = 1'b0;
      clear_exp(c);
    end
  endtask

  // One rising edge of the reference: reads see memory before this edge's writes.
  task automatic model_edge();
    int wa[$];
    logic [7:0] wd[$];
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_resp[c]) begin
        if (resp_ready[c]) begin
          m_resp[c] = 1'b0;
          clear_exp(c);
        end
      end else if (m_busy[c]) begin
        if (cyc == m_due[c]) begin
          m_busy[c] = 1'b0;
          m_resp[c] = 1'b1;
          e_wr[c] = m_wr[c];
          for (int l = 0; l < LANES; l++) begin
            e_lv[c][l] = 1'b0;
            e_err[c][l] = 1'b0;
            e_rd[c][l*8 +: 8] = 8'h00;
            if (m_en[c][l]) begin
              if (m_addr[c][l] >= ADDR_W'(MEM_BYTES)) begin
                e_err[c][l] = 1'b1;
              end else begin
                e_lv[c][l] = 1'b1;
                if (m_wr[c]) begin
                  wa.push_back(int'(m_addr[c][l]));
                  wd.push_back(m_wd[c][l]);
                end else begin
                  e_rd[c][l*8 +: 8] = mem_m[int'(m_addr[c][l])];
                end
              end
            end
          end
        end
      end else if (req_valid[c]) begin
        m_busy[c] = 1'b1;
        m_wr[c] = req_wr[c];
        m_en[c] = req_lane_en[c*LANES +: LANES];
        for (int l = 0; l < LANES; l++) begin
          m_addr[c][l] = req_addr[(c*LANES+l)*ADDR_W +: ADDR_W];
          m_wd[c][l] = req_wdata[(c*LANES+l)*8 +: 8];
        end
        m_due[c] = cyc + (req_wr[c] ? WR_LAT : RD_LAT);
      end
    end
    for (int i = 0; i < wa.size(); i++) mem_m[wa[i]] = wd[i];
    cyc++;
  endtask

  // scoreboard comparison of every output against the model
  task automatic check_all();
    for (int c = 0; c < NUM_CH; c++) begin
      chk("req_ready", c, 64'(req_ready[c]), 64'(!m_busy[c] && !m_resp[c]));
      chk("resp_valid", c, 64'(resp_valid[c]), 64'(m_resp[c]));
      chk("resp_wr", c, 64'(resp_wr[c]), 64'(e_wr[c]));
      chk("lane_valid", c, 64'(resp_lane_valid[c*LANES +: LANES]), 64'(e_lv[c]));
      chk("resp_err", c, 64'(resp_err[c*LANES +: LANES]), 64'(e_err[c]));
      chk("rdata", c, 64'(resp_rdata[c*LANES*8 +: LANES*8]), 64'(e_rd[c]));
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_lane(input int c, input int l, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    req_addr[(c*LANES+l)*ADDR_W +: ADDR_W] = a;
    req_wdata[(c*LANES+l)*8 +: 8] = d;
  endtask

  task automatic issue(input int c, input bit wr, input logic [LANES-1:0] en);
    req_valid[c] = 1'b1;
    req_wr[c] = wr;
    req_lane_en[c*LANES +: LANES] = en;
  endtask

  function automatic bit any_active();
    bit r = 1'b0;
    for (int c = 0; c < NUM_CH; c++) r |= m_busy[c] | m_resp[c];
    return r;
  endfunction

  task automatic run_until_idle();
    int k;
    cycle();
    req_valid = '0;
    k = 0;
    while (any_active() && k < 200) begin
      cycle();
      k++;
    end
    if (any_active()) chk("idle_timeout", 0, 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    #2 reset = 1'b1;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    int s = $urandom_range(0, 15);
    if (s == 0) return {$urandom, $urandom};
    if (s < 3) return ADDR_W'($urandom_range(0, 1100));
    return ADDR_W'($urandom_range(0, 31));
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    #2 reset = 1'b1;

    // preload every byte so later reads are fully defined
    for (int r = 0; r < MEM_BYTES / NL; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int l = 0; l < LANES; l++) set_lane(c, l, ADDR_W'(r*NL + c*LANES + l), 8'($urandom));
        issue(c, 1'b1, 8'hFF);
      end
      run_until_idle();
    end

    // write then read 0x10..0x17
    for (int l = 0; l < LANES; l++) set_lane(0, l, ADDR_W'(16 + l), 8'(8'hA0 + l));
    issue(0, 1'b1, 8'hFF);
    run_until_idle();
    issue(0, 1'b0, 8'hFF);
    run_until_idle();

    // partial lanes and out-of-range
    set_lane(1, 0, 64'h3FF, 8'h00);
    set_lane(1, 2, 64'h400, 8'h00);
    issue(1, 1'b0, 8'h05);
    run_until_idle();
    set_lane(1, 0, 64'h400, 8'h5A);
    issue(1, 1'b1, 8'h01);
    run_until_idle();
    set_lane(1, 0, 64'h000, 8'h00);
    issue(1, 1'b0, 8'h01);
    run_until_idle();
    set_lane(1, 0, 64'hFFFF_0000_0000_0010, 8'h77);
    issue(1, 1'b0, 8'h01);
    run_until_idle();
    issue(1, 1'b0, 8'h00);
    run_until_idle();

    // backpressure with a request held during RESP
    resp_ready = '0;
    for (int l = 0; l < LANES; l++) set_lane(0, l, ADDR_W'(16 + l), 8'h00);
    issue(0, 1'b0, 8'hFF);
    repeat (RD_LAT + 8) cycle();
    resp_ready = '1;
    repeat (3) cycle();
    req_valid = '0;
    run_until_idle();

    // simultaneous commit across channels, and lane conflict within a channel
    set_lane(0, 0, 64'h20, 8'h11);
    set_lane(1, 0, 64'h20, 8'h22);
    set_lane(0, 3, 64'h30, 8'h33);
    set_lane(0, 5, 64'h30, 8'h55);
    issue(0, 1'b1, 8'h29);
    issue(1, 1'b1, 8'h01);
    run_until_idle();
    set_lane(0, 0, 64'h20, 8'h00);
    set_lane(0, 1, 64'h30, 8'h00);
    issue(0, 1'b0, 8'h03);
    run_until_idle();

    // mixed latency: same-edge accept, then read coinciding with a write commit
    set_lane(0, 0, 64'h40, 8'h00);
    set_lane(1, 0, 64'h40, 8'hC3);
    issue(0, 1'b0, 8'h01);
    issue(1, 1'b1, 8'h01);
    run_until_idle();
    set_lane(1, 0, 64'h60, 8'h3C);
    issue(1, 1'b1, 8'h01);
    cycle();
    req_valid = '0;
    cycle();
    set_lane(0, 0, 64'h60, 8'h00);
    issue(0, 1'b0, 8'h01);
    run_until_idle();
    issue(0, 1'b0, 8'h01);
    run_until_idle();

    // asynchronous reset while a write is in BUSY
    set_lane(0, 0, 64'h50, 8'hEE);
    issue(0, 1'b1, 8'h01);
    cycle();
    req_valid = '0;
    cycle();
    do_reset();
    issue(0, 1'b0, 8'h01);
    run_until_idle();

    // random traffic
    repeat (3000) begin
      for (int c = 0; c < NUM_CH; c++) begin
        req_valid[c] = ($urandom_range(0, 1) == 1);
        req_wr[c] = ($urandom_range(0, 1) == 1);
        req_lane_en[c*LANES +: LANES] = 8'($urandom);
        resp_ready[c] = ($urandom_range(0, 9) < 7);
        for (int l = 0; l < LANES; l++) set_lane(c, l, rnd_addr(), 8'($urandom));
      end
      cycle();
    end
    resp_ready = '1;
    req_valid = '0;
    run_until_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dram_model_mc.md
Name: dram_model_mc

Overview:
- Parametrised multi-channel DRAM timing model for simulation and FPGA prototyping of the protobuf engine's memory side.
- Each of NUM_CH independent channels accepts one multi-lane byte request at a time through a valid/ready handshake.
- A request completes after a programmable read or write latency and returns a held response with per-lane valid and error flags.
- All channels share one byte-addressed storage array of MEM_BYTES entries.

Parameters:
NUM_CH, 2, number of independent request channels
LANES, 8, byte lanes per channel request
ADDR_W, 64, address width per lane
MEM_BYTES, 1024, storage size in bytes; valid addresses are 0..MEM_BYTES-1
RD_LAT, 20, read latency in cycles (must be >= 1)
WR_LAT, 20, write latency in cycles (must be >= 1)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel request ready
req_wr  in  NUM_CH  1 = write, 0 = read
req_lane_en  in  NUM_CH*LANES  per-lane enable; lane l of channel c is bit c*LANES+l
req_addr  in  NUM_CH*LANES*ADDR_W  per-lane byte address
req_wdata  in  NUM_CH*LANES*8  per-lane write byte
resp_valid  out  NUM_CH  per-channel response valid
resp_ready  in  NUM_CH  per-channel response accept
resp_wr  out  NUM_CH  copy of the accepted req_wr
resp_lane_valid  out  NUM_CH*LANES  lanes enabled and completed without error
resp_err  out  NUM_CH*LANES  enabled lane whose address is >= MEM_BYTES
resp_rdata  out  NUM_CH*LANES*8  read data; 0 for writes, disabled lanes and errored lanes

Behaviour:
- Reset (reset=0, asynchronous):
  - All channel FSMs go to IDLE; counters clear.
  - All outputs go to 0, except req_ready, which is 1 once in IDLE.
  - Storage contents are not reset and are preserved across reset.
  - An in-flight request is discarded; a pending write is never committed.
- Per-channel FSM, with states IDLE, BUSY and RESP:
  - IDLE: req_ready=1. When req_valid=1 at an edge, latch wr, lane_en, addr and wdata; load cnt=0; go to BUSY.
  - BUSY: req_ready=0. Each edge increments cnt. At the edge where cnt == LAT-1 (LAT is RD_LAT or WR_LAT, chosen by the latched wr), perform the access and enter RESP.
  - RESP: resp_valid=1. All resp_* outputs are registered and held stable until resp_ready=1 at an edge, then the FSM returns to IDLE.
- Timing:
  - resp_valid rises exactly LAT edges after the accepting edge.
  - There is no accept in the cycle RESP is exited. Minimum request-to-request spacing is LAT+2 cycles with resp_ready tied high.
- Access rules per lane:
  - Disabled lanes: resp_lane_valid=0, resp_err=0, rdata=0.
  - Enabled lanes with addr >= MEM_BYTES (full ADDR_W compare): resp_err=1, the write is dropped, rdata=0.
  - Otherwise resp_lane_valid=1. A read captures mem[addr] at the access edge; a write stores wdata at the access edge.
  - A request with all lanes disabled is still accepted and answered, with all lane flags 0.
- Write conflicts:
  - Within one channel, same address on several lanes: the highest lane index wins.
  - Across channels committing in the same edge to the same address: the highest channel index wins; within it, the highest lane wins.
- Read/write ordering:
  - A read whose access edge coincides with another channel's write commit returns the old (pre-write) data.
  - Writes committed at an earlier edge are visible.
- Handshake rules:
  - req_* inputs are ignored outside IDLE.
  - resp_ready is ignored outside RESP.
  - Channels are fully independent: no arbitration stall, no ordering between channels.

Test Plan:
- Write then read, RD_LAT=WR_LAT=20, resp_ready=1. Ch0 writes lanes 0..7 at addr 0x10..0x17 with data 0xA0..0xA7; response at +20 edges with resp_wr=1 and lane_valid=0xFF. Ch0 then reads the same addresses; rdata=0xA0..0xA7 at +20, lane_valid=0xFF.
- Out-of-range and partial lanes. Ch1 reads with lane_en=0x05: lane0 addr 0x3FF, lane2 addr 0x400. Response: lane_valid=0x01, err=0x04, lane0 rdata=mem[0x3FF], lane2 rdata=0. Then a write to 0x400 is dropped and a read of 0x000 is unaffected.
- Backpressure. Hold resp_ready=0 for 7 cycles after resp_valid rises → outputs stable and req_ready=0 throughout. Assert resp_ready → IDLE next edge. A new request presented during RESP is not accepted until IDLE.
- Simultaneous commit. Ch0 and ch1 both write addr 0x20 (0x11 and 0x22) at the same edge; read-back gives 0x22. Same-channel lanes 3 and 5 both target 0x30 → lane5 data stored.
- Mixed latency. With RD_LAT=3 and WR_LAT=5, ch0 read and ch1 write accepted at the same edge. Ch0 responds at +3 and returns the old byte; ch1 responds at +5. A later read sees the new byte.
- Reset mid-BUSY. Drive reset=0 asynchronously mid-cycle during a write's BUSY → outputs go to 0 immediately without a clock edge. After release, req_ready=1 and a read of the target address returns the pre-write value.
